dly_tap_cal_ctrl: RTL and testbench
===================================

DLY_TAP_CAL_CTRL -- requirements
Module: dly_tap_cal_ctrl

Interface
REQ-001 SHALL have parameter: TAP_W, 4, width of tap-select code (taps 0 .. 2^TAP_W-1).
REQ-002 SHALL have parameter: SETTLE, 4, clock cycles waited after every tap change before sampling (legal 1..255).
REQ-003 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: START  input  1  calibration request, sampled on CLK.
REQ-006 SHALL have port: PD  input  1  phase-detector sample; 1 = delayed edge at/after reference (target reached).
REQ-007 SHALL have port: TAP  output  TAP_W  tap-select code driving the delay-chain mux.
REQ-008 SHALL have port: BUSY  output  1  calibration in progress.
REQ-009 SHALL have port: LOCK  output  1  calibration succeeded; TAP holds the locked code.
REQ-010 SHALL have port: FAIL  output  1  maximum tap reached without PD=1.

Function
REQ-011 SHALL implement states IDLE, SETTLE, SAMPLE, LOCKED, FAILED; all outputs registered.
REQ-012 IDLE/LOCKED/FAILED + START=1 SHALL: TAP<=0, LOCK<=0, FAIL<=0, BUSY<=1, settle counter loaded, enter SETTLE.
REQ-013 START while BUSY=1 SHALL be ignored, with no effect on state, TAP or counters.
REQ-014 SETTLE SHALL last exactly SETTLE cycles, then enter SAMPLE; TAP stable throughout.
REQ-015 SAMPLE SHALL last S cycles (S=1 base; S=3 per REQ-024), then evaluate the sampled PD value.
REQ-016 Evaluated PD=1 SHALL enter LOCKED: BUSY<=0, LOCK<=1, TAP unchanged.
REQ-017 Evaluated PD=0 with TAP<2^TAP_W-1 SHALL: TAP<=TAP+1, reload settle counter, enter SETTLE.
REQ-018 Evaluated PD=0 with TAP=2^TAP_W-1 SHALL enter FAILED: BUSY<=0, FAIL<=1, TAP held at max; TAP SHALL never wrap to 0.
REQ-019 Timing: with C=SETTLE+S and START sampled at edge 0, tap k SHALL be evaluated at edge (k+1)*C; LOCK/FAIL SHALL be visible after that edge.
REQ-020 LOCK and FAIL SHALL be mutually exclusive and never asserted while BUSY=1.
REQ-021 LOCK/FAIL SHALL persist until the next accepted START or reset.
REQ-022 PD SHALL be ignored outside SAMPLE.

Reset
REQ-023 RN=0 SHALL immediately and asynchronously force IDLE, TAP=0, BUSY=0, LOCK=0, FAIL=0, and clear counters, including mid-calibration; START SHALL be ignored while RN=0; the first START after RN deasserts SHALL start a fresh sweep from tap 0.

Configuration
REQ-024 Macro DLY_TAP_CAL_MAJ_EN defined: S=3; PD sampled on 3 consecutive SAMPLE cycles and the majority value evaluated. Undefined: S=1; single-sample evaluation; no vote logic present.

Verification
REQ-025 Scenario, SETTLE=4, base build, PD=1 from tap 3: START pulse at edge 0 -> LOCK=1, TAP=3, BUSY=0 after edge 20.
REQ-026 Scenario, PD held 0, TAP_W=4, SETTLE=4, base build: START -> TAP steps 0..15, FAIL=1 after edge 80, TAP=15, no wrap.
REQ-027 Scenario: RN pulsed low while TAP=6 in SETTLE -> all outputs 0 immediately; next START -> sweep restarts at TAP=0.
REQ-028 Scenario: START re-pulsed at edges 3 and 9 during a sweep -> no change vs REQ-025 timing; START after LOCK -> LOCK clears, TAP=0, BUSY=1.
REQ-029 Scenario, DLY_TAP_CAL_MAJ_EN, SETTLE=4: PD pattern 1,0,0 in tap-0 SAMPLE window, then 1 from tap 1 -> tap 0 rejected; LOCK after edge 14, TAP=1.

Source files
------------

// File: rtl/dly_tap_cal_ctrl.sv
//============================================================================
// Module  : dly_tap_cal_ctrl
// Purpose : Delay-line tap calibration controller. On START it sweeps the
//           tap-select code upward from 0, waits SETTLE cycles after every
//           tap change, samples the phase detector and locks on the first
//           tap where PD reports the target edge reached. If the last tap
//           is evaluated without PD=1 the sweep ends in FAIL with TAP held
//           at its maximum.
// Ports   : CLK   - clock, rising edge
//           RN    - asynchronous active-low reset
//           START - calibration request (ignored while BUSY)
//           PD    - phase-detector sample, only observed in SAMPLE
//           TAP   - tap-select code to the delay-chain mux
//           BUSY  - calibration in progress
//           LOCK  - calibration succeeded, TAP holds the locked code
//           FAIL  - all taps tried without PD=1
// Config  : DLY_TAP_CAL_MAJ_EN - when defined, PD is sampled on three
//           consecutive SAMPLE cycles and the majority value is evaluated;
//           otherwise a single sample is evaluated.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module dly_tap_cal_ctrl #(
  parameter int TAP_W  = 4,
  parameter int SETTLE = 4
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             PD,
  output logic [TAP_W-1:0] TAP,
  output logic             BUSY,
  output logic             LOCK,
  output logic             FAIL
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAILED = 3'd4
  } state_t;

  localparam logic [TAP_W-1:0] C_TAP_MAX     = '1;
  // The counter is loaded with SETTLE-1 so that SETTLE reaches zero on the
  // SETTLE-th edge after entry, giving exactly SETTLE cycles in ST_SETTLE.
  localparam logic [7:0]       C_SETTLE_LOAD = 8'(SETTLE - 1);

  state_t     r_state;
  logic [7:0] r_settle_cnt;
  logic       w_eval_now;  // this SAMPLE edge produces the final decision
  logic       w_pd_eval;   // PD value the decision is based on

`ifdef DLY_TAP_CAL_MAJ_EN
  logic [1:0] r_smp_cnt;
  logic [1:0] r_votes;

  // Third sample is taken live on the deciding edge; the first two are held.
  assign w_eval_now = (r_smp_cnt == 2'd2);
  assign w_pd_eval  = (r_votes[1] & r_votes[0]) |
                      (r_votes[1] & PD) |
                      (r_votes[0] & PD);
`else
  assign w_eval_now = 1'b1;
  assign w_pd_eval  = PD;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 8'd0;
      TAP          <= '0;
      BUSY         <= 1'b0;
      LOCK         <= 1'b0;
      FAIL         <= 1'b0;
`ifdef DLY_TAP_CAL_MAJ_EN
      r_smp_cnt    <= 2'd0;
      r_votes      <= 2'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_LOCKED, ST_FAILED: begin
          if (START) begin
            TAP          <= '0;
            LOCK         <= 1'b0;
            FAIL         <= 1'b0;
            BUSY         <= 1'b1;
            r_settle_cnt <= C_SETTLE_LOAD;
            r_state      <= ST_SETTLE;
          end
        end

        ST_SETTLE: begin
          if (r_settle_cnt == 8'd0) begin
            r_state   <= ST_SAMPLE;
`ifdef DLY_TAP_CAL_MAJ_EN
            r_smp_cnt <= 2'd0;
`endif
          end else begin
            r_settle_cnt <= r_settle_cnt - 8'd1;
          end
        end

        ST_SAMPLE: begin
          if (w_eval_now) begin
            if (w_pd_eval) begin
              BUSY    <= 1'b0;
              LOCK    <= 1'b1;
              r_state <= ST_LOCKED;
            end else if (TAP == C_TAP_MAX) begin
              // Last tap exhausted: hold at max rather than wrapping.
              BUSY    <= 1'b0;
              FAIL    <= 1'b1;
              r_state <= ST_FAILED;
            end else begin
              TAP          <= TAP + TAP_W'(1);
              r_settle_cnt <= C_SETTLE_LOAD;
              r_state      <= ST_SETTLE;
            end
          end
`ifdef DLY_TAP_CAL_MAJ_EN
          else begin
            r_votes   <= {r_votes[0], PD};
            r_smp_cnt <= r_smp_cnt + 2'd1;
          end
`endif
        end

        default: begin
          r_state <= ST_IDLE;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dly_tap_cal_ctrl.sv
//============================================================================
// Module  : tb_dly_tap_cal_ctrl
// Purpose : Self-checking bench for dly_tap_cal_ctrl. Table of sweep records
//           (PD threshold tap, START re-pulse edges, expected outcome) plus
//           hand-written reset, single/majority-sample sequences.
// Revision: 1.0 - initial release
//============================================================================
`default_nettype none

module tb_dly_tap_cal_ctrl;

  localparam int TAP_W  = 4;
  localparam int SETTLE = 4;
`ifdef DLY_TAP_CAL_MAJ_EN
  localparam int S = 3;
`else
  localparam int S = 1;
`endif
  localparam int C = SETTLE + S;

  logic             CLK = 1'b0;
  logic             RN = 1'b0;
  logic             START = 1'b0;
  logic             PD;
  logic [TAP_W-1:0] TAP;
  logic             BUSY;
  logic             LOCK;
  logic             FAIL;

  // PD either follows a threshold on the current tap or is driven by hand.
  int   pd_from   = 16;
  logic pd_man_en = 1'b0;
  logic pd_man    = 1'b0;
  assign PD = pd_man_en ? pd_man : (int'(TAP) >= pd_from);

  int total = 0;
  int bad   = 0;

  dly_tap_cal_ctrl #(.TAP_W(TAP_W), .SETTLE(SETTLE)) dut (
    .CLK  (CLK),
    .RN   (RN),
    .START(START),
    .PD   (PD),
    .TAP  (TAP),
    .BUSY (BUSY),
    .LOCK (LOCK),
    .FAIL (FAIL)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int pd_from;    // first tap with PD=1 (16 = never)
    int rp1;        // edges with a spurious START (-1 = none)
    int rp2;
    int exp_tap;
    int exp_lock;
    int exp_fail;
    int exp_edge;   // edge at which BUSY drops
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic run_sweep(input vec_t v);
    int  e;
    bit  done;
    pd_man_en = 1'b0;
    pd_from   = v.pd_from;
    START     = 1'b1;
    tick();
    START = 1'b0;
    chk("start_busy", 32'(BUSY), 1);
    chk("start_tap",  32'(TAP),  0);
    chk("start_lock", 32'(LOCK), 0);
    chk("start_fail", 32'(FAIL), 0);
    e    = 0;
    done = 1'b0;
    while (!done && e < 300) begin
      START = ((e + 1) == v.rp1) || ((e + 1) == v.rp2);
      tick();
      START = 1'b0;
      e++;
      if (BUSY) begin
        chk("tap_track", 32'(TAP), 32'(e / C));
        chk("lf_while_busy", 32'({LOCK, FAIL}), 0);
      end else begin
        done = 1'b1;
      end
    end
    chk("sweep_timeout", 32'(done), 1);
    chk("end_edge", 32'(e), 32'(v.exp_edge));
    chk("end_tap",  32'(TAP), 32'(v.exp_tap));
    chk("end_lock", 32'(LOCK), 32'(v.exp_lock));
    chk("end_fail", 32'(FAIL), 32'(v.exp_fail));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{3,  -1, -1, 3,  1, 0, 4 * C};
    vecs[1] = '{0,  -1, -1, 0,  1, 0, 1 * C};
    vecs[2] = '{16, -1, -1, 15, 0, 1, 16 * C};
    vecs[3] = '{15, -1, -1, 15, 1, 0, 16 * C};
    vecs[4] = '{3,   3,  9, 3,  1, 0, 4 * C};
    vecs[5] = '{9,  -1, -1, 9,  1, 0, 10 * C};
    vecs[6] = '{16,  2, -1, 15, 0, 1, 16 * C};

    // Reset state, with START asserted while in reset.
    START = 1'b1;
    tick();
    tick();
    chk("rst_tap",  32'(TAP),  0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_lock", 32'(LOCK), 0);
    chk("rst_fail", 32'(FAIL), 0);
    START = 1'b0;
    #2 RN = 1'b1;
    tick();
    chk("post_rst_busy", 32'(BUSY), 0);

    for (int i = 0; i < 7; i++) begin
      run_sweep(vecs[i]);
      tick();
      tick();
      chk("hold_lock", 32'(LOCK), 32'(vecs[i].exp_lock));
      chk("hold_fail", 32'(FAIL), 32'(vecs[i].exp_fail));
      chk("hold_tap",  32'(TAP),  32'(vecs[i].exp_tap));
    end

    // Asynchronous reset in the middle of the tap-6 settle window.
    pd_from = 16;
    START   = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (TAP != 4'd6 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk("mid_tap6", 32'(TAP), 6);
    chk("mid_busy", 32'(BUSY), 1);
    #2 RN = 1'b0;
    #1;
    chk("async_tap",  32'(TAP),  0);
    chk("async_busy", 32'(BUSY), 0);
    chk("async_lock", 32'(LOCK), 0);
    chk("async_fail", 32'(FAIL), 0);
    START = 1'b1;
    tick();
    START = 1'b0;
    #2 RN = 1'b1;
    tick();
    chk("rst_start_ignored", 32'(BUSY), 0);
    run_sweep('{2, -1, -1, 2, 1, 0, 3 * C});

    // Hand-driven PD: held 1 through tap-0 settle (must be ignored), a
    // rejecting sample pattern in the tap-0 window, then 1 from tap 1.
    pd_man_en = 1'b1;
    pd_man    = 1'b1;
    START     = 1'b1;
    tick();
    START = 1'b0;
    for (int e = 1; e <= 2 * C; e++) begin
      if (e <= SETTLE)
        pd_man = 1'b1;
      else if (e <= C)
`ifdef DLY_TAP_CAL_MAJ_EN
        pd_man = (e == SETTLE + 1);
`else
        pd_man = 1'b0;
`endif
      else
        pd_man = 1'b1;
      tick();
      if (e == C) begin
        chk("man_tap0_rejected", 32'(TAP), 1);
        chk("man_busy_mid", 32'(BUSY), 1);
      end
      if (e == 2 * C - 1)
        chk("man_not_yet_locked", 32'({BUSY, LOCK}), 32'(2'b10));
      if (e == 2 * C) begin
        chk("man_lock", 32'(LOCK), 1);
        chk("man_tap",  32'(TAP),  1);
        chk("man_busy", 32'(BUSY), 0);
      end
    end
    pd_man_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
